serial_sub: RTL and testbench
=============================

# serial_sub

Bit-serial, LSB-first N-bit subtractor built around a single half/full-subtractor cell and a borrow flip-flop. It is the subtract direction of the adder cells in the arithmetic examples. It latches two operands on a start pulse, resolves one bit per clock, then reports the difference and final borrow with a one-cycle done pulse. It sits between a stimulus or control source and any consumer that wants `a - b` at minimal logic cost.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.
- `sys_clk`  input  1  system clock; all state changes on the rising edge.
- `sys_rst`  input  1  reset, asynchronous and active-high.
- `start`  input  1  request pulse, sampled only in IDLE.
- `a`  input  WIDTH  minuend, captured on an accepted start.
- `b`  input  WIDTH  subtrahend, captured on an accepted start.
- `busy`  output  1  high while in RUN.
- `done`  output  1  single-cycle pulse in DONE.
- `diff`  output  WIDTH  result register.
- `borrow`  output  1  final borrow-out; 1 when a < b unsigned.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: processes exactly WIDTH bit-steps.
  - DONE: lasts one cycle, then returns to IDLE.
- Transitions:
  - IDLE→RUN on `start`=1.
  - RUN→DONE after bit index WIDTH-1 is processed.
  - DONE→IDLE unconditionally.
- On accept:
  - Copy `a` and `b` into shift registers `a_sh` and `b_sh`.
  - Clear the borrow flop `br`, bit counter `cnt`, and result shift register `d_sh`.
- Each RUN cycle:
  - `d = a_sh[0] ^ b_sh[0] ^ br`.
  - `br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br)`.
  - Shift `a_sh` and `b_sh` right by 1.
  - Shift `d` into the MSB of `d_sh`.
  - `cnt` increments by 1.
- On entering DONE:
  - `diff` ← `d_sh`.
  - `borrow` ← `br_next` of the last bit.
- `diff` and `borrow` hold their values until the next DONE or reset.
- Arithmetic is unsigned modulo 2^WIDTH: `diff = (a - b) mod 2^WIDTH`, `borrow = (a < b)`.
- `start` is ignored in RUN and DONE: no restart and no operand capture.
- Changes on `a`/`b` after capture have no effect.

## Timing
- Reset values: state = IDLE; `busy`=0, `done`=0, `diff`=0, `borrow`=0. Internal shift registers and counter are also cleared.
- Reset asserted mid-RUN or in DONE:
  - Aborts immediately.
  - No `done` pulse for the aborted operation.
  - `diff`/`borrow` return to 0.
- Start accepted at edge k:
  - `busy`=1 for cycles k+1 … k+WIDTH.
  - `done`=1 for cycle k+WIDTH+1, with `diff`/`borrow` valid from that cycle.
  - `busy`=0 during DONE.
- Latency is start-edge to done = WIDTH+1 cycles. Throughput is one operation per WIDTH+2 cycles.
- Earliest next accept is the first IDLE cycle after DONE, i.e. `start` sampled at edge k+WIDTH+2.
- A `start` held high continuously produces back-to-back operations at this rate.
- `cnt` is ⌈log2(WIDTH)⌉ bits and never wraps during RUN.

## Configuration
- Macro: `SERIAL_SUB_ADDSUB_EN`.
- Defined:
  - Adds input port `mode` (1 bit), captured on accept.
  - `mode`=0 subtracts exactly as above.
  - `mode`=1 adds:
    - `d = a^b^c`.
    - `c_next = (a&b) | ((a^b)&c)`.
    - The `borrow` output carries the final carry-out.
  - Latency is identical in both modes.
- Undefined: no `mode` port; the block always subtracts.

## Test plan
- WIDTH=8, after reset release: `a`=0x5A, `b`=0x3C, `start` for 1 cycle → `busy` for 8 cycles, `done` at the 9th cycle after the start edge, `diff`=0x1E, `borrow`=0.
- `a`=0x00, `b`=0x01 → `diff`=0xFF, `borrow`=1. Then `a`=0x80, `b`=0x80 → `diff`=0x00, `borrow`=0.
- During RUN, pulse `start` with `a`=0xFF, `b`=0x00 → ignored; the in-flight result is unchanged, with exactly one `done` pulse.
- Assert `sys_rst` at the 4th RUN cycle → all outputs 0 immediately, no `done`. A new start after release of 0x10−0x01 gives `diff`=0x0F.
- Hold `start`=1 continuously with `a`=0x03, `b`=0x05 → `done` every 10 cycles, each with `diff`=0xFE, `borrow`=1.
- With `SERIAL_SUB_ADDSUB_EN` defined and `mode`=1: 0xFF + 0x01 → `diff`=0x00, `borrow`(carry)=1. Then `mode`=0: 0x01 − 0xFF → `diff`=0x02, `borrow`=1.

Source files
------------

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial LSB-first subtractor; SERIAL_SUB_ADDSUB_EN adds a mode port for add/subtract
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
`ifdef SERIAL_SUB_ADDSUB_EN
    input  logic             mode,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [WIDTH-1:0] d_sh_next;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             br_next;
    logic             bit_d;
    logic             last_bit;
`ifdef SERIAL_SUB_ADDSUB_EN
    logic             mode_r;
`endif

    assign last_bit  = (cnt == LAST);
    assign d_sh_next = {bit_d, d_sh[WIDTH-1:1]};

    // One full-subtractor (or full-adder in add mode) cell on the current LSBs
    always_comb begin
        bit_d   = a_sh[0] ^ b_sh[0] ^ br;
        br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
`ifdef SERIAL_SUB_ADDSUB_EN
        if (mode_r) begin
            br_next = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & br);
        end
`endif
    end

    // State register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, per-bit shifting and result commit
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_ADDSUB_EN
            mode_r <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        d_sh <= '0;
                        cnt  <= '0;
                        br   <= 1'b0;
`ifdef SERIAL_SUB_ADDSUB_EN
                        mode_r <= mode;
`endif
                    end
                end
                S_RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    d_sh <= d_sh_next;
                    br   <= br_next;
                    // Counter holds at the last index so it never wraps
                    if (!last_bit) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        diff   <= d_sh_next;
                        borrow <= br_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - self-checking bench for serial_sub (add mode exercised when SERIAL_SUB_ADDSUB_EN is defined)
module tb_serial_sub;

    localparam int W = 8;

    logic         sys_clk;
    logic         sys_rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_ADDSUB_EN
    logic         mode_v;
`endif

    int checks = 0;
    int errors = 0;

    serial_sub #(.WIDTH(W)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (start),
`ifdef SERIAL_SUB_ADDSUB_EN
        .mode    (mode_v),
`endif
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .borrow  (borrow)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         br;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic on integers
    function automatic void model(input int unsigned x, input int unsigned y, input logic m,
                                  output logic [W-1:0] d, output logic br);
        int unsigned full;
        full = 1 << W;
        if (m) begin
            d  = W'((x + y) % full);
            br = ((x + y) >= full);
        end else begin
            d  = W'((x + full - y) % full);
            br = (x < y);
        end
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Full operation from IDLE with fixed-latency checks
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] ed, input logic eb, input string name);
        logic run_ok;
        a = ta;
        b = tb_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        run_ok = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (!(busy === 1'b1 && done === 1'b0)) run_ok = 1'b0;
            tick();
        end
        check({name, " busy_window"}, 32'(run_ok), 32'd1);
        check({name, " done"}, 32'(done), 32'd1);
        check({name, " busy_in_done"}, 32'(busy), 32'd0);
        check({name, " diff"}, 32'(diff), 32'(ed));
        check({name, " borrow"}, 32'(borrow), 32'(eb));
        tick();
        check({name, " done_single"}, 32'(done), 32'd0);
        check({name, " diff_hold"}, 32'(diff), 32'(ed));
    endtask

    initial begin
        int n_done;
        int last_c;
        logic [W-1:0] ed;
        logic eb;
        logic m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, d: 8'h1E, br: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, d: 8'hFF, br: 1'b1};
        vecs[2] = '{a: 8'h80, b: 8'h80, d: 8'h00, br: 1'b0};
        vecs[3] = '{a: 8'h03, b: 8'h05, d: 8'hFE, br: 1'b1};
        vecs[4] = '{a: 8'h10, b: 8'h01, d: 8'h0F, br: 1'b0};
        vecs[5] = '{a: 8'hFF, b: 8'h00, d: 8'hFF, br: 1'b0};
        vecs[6] = '{a: 8'h00, b: 8'hFF, d: 8'h01, br: 1'b1};
        vecs[7] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, br: 1'b0};

        sys_rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
`ifdef SERIAL_SUB_ADDSUB_EN
        mode_v = 1'b0;
`endif
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset borrow", 32'(borrow), 32'd0);
        sys_rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, $sformatf("vec%0d", i));
        end

        // start pulsed during RUN must be ignored
        a = 8'h5A;
        b = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 2 * W; i++) begin
            if (done === 1'b1) begin
                n_done++;
                check("ignore diff", 32'(diff), 32'h1E);
                check("ignore borrow", 32'(borrow), 32'd0);
            end
            tick();
        end
        check("ignore done_count", 32'(n_done), 32'd1);

        // reset in the 4th RUN cycle
        a = 8'hC3;
        b = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_abort busy", 32'(busy), 32'd1);
        sys_rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort diff", 32'(diff), 32'd0);
        check("abort borrow", 32'(borrow), 32'd0);
        tick();
        sys_rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (done === 1'b1) n_done++;
            tick();
        end
        check("abort no_done", 32'(n_done), 32'd0);
        run_op(8'h10, 8'h01, 8'h0F, 1'b0, "after_abort");

        // start held high: one result every W+2 cycles
        a = 8'h03;
        b = 8'h05;
        start = 1'b1;
        n_done = 0;
        last_c = -1;
        for (int c = 0; c < 45; c++) begin
            tick();
            if (done === 1'b1) begin
                n_done++;
                check("b2b diff", 32'(diff), 32'hFE);
                check("b2b borrow", 32'(borrow), 32'd1);
                if (last_c >= 0) check("b2b interval", 32'(c - last_c), 32'(W + 2));
                else check("b2b first_latency", 32'(c), 32'(W));
                last_c = c;
            end
        end
        check("b2b done_count", 32'(n_done), 32'd4);
        start = 1'b0;
        for (int i = 0; i < W + 4; i++) tick();
        check("b2b drained", 32'(busy), 32'd0);

`ifdef SERIAL_SUB_ADDSUB_EN
        mode_v = 1'b1;
        run_op(8'hFF, 8'h01, 8'h00, 1'b1, "add_ff_01");
        mode_v = 1'b0;
        run_op(8'h01, 8'hFF, 8'h02, 1'b1, "sub_01_ff");
`endif

        // randomized operands against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            m = 1'b0;
`ifdef SERIAL_SUB_ADDSUB_EN
            m = 1'($urandom);
            mode_v = m;
`endif
            model(32'(ra), 32'(rb), m, ed, eb);
            run_op(ra, rb, ed, eb, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
